clk_div_sched: RTL and testbench

Run/stop and reconfiguration controller for the team's counter-based clock divider. Starts and stops the divided clock cleanly, accepts new divide ratios over a valid/ready handshake and applies them only at full-period boundaries, so clk_out never has a runt pulse. Sits between the control or register logic and any logic clocked or paced by the divided clock.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_core.sv | 65 ++++++
 rtl/clk_div_sched.sv | 111 +++++++++++
 tb/tb_clk_div_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the clock-divider run/stop scheduler.
package clk_div_pkg;

    localparam int CNT_W_DEF = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with 50% toggle, rising-edge tick and the active divisor register.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 250000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             bnd_o,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] div_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // Gated by run so an idle counter sitting at 0 never looks like a boundary when div is 1.
    assign bnd_o = run_i && (count_q == div_q - CNT_W'(1));

    always_comb begin
        count_d = '0;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        div_d   = div_q;
        if (run_i && !clr_i && !bnd_o) begin
            count_d = count_q + CNT_W'(1);
        end
        if (clr_i) begin
            clk_d = 1'b0;
        end else if (bnd_o) begin
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
        end
        if (load_i) begin
            div_d = load_val_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            div_q   <= CNT_W'(DEF_DIV);
        end else begin
            count_q <= count_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign div_o     = div_q;

endmodule

// File: rtl/clk_div_sched.sv
// Run/stop FSM, pending-divisor register and cfg handshake around clk_div_core.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 250000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] active_div
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             run, clr, bnd, load;
    logic [CNT_W-1:0] load_val;
    logic             accept, good, apply;

    assign run = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (!clk_out) begin
                    // Already low: park now and suppress any 0->1 boundary this cycle.
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (bnd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready = ~pend_valid_q;
    assign accept    = cfg_valid && cfg_ready;
    assign good      = accept && (cfg_div != '0);
    // Pending divisor lands on a falling boundary or while parked in IDLE.
    assign apply     = pend_valid_q && ((bnd && clk_out) || (state_q == IDLE));

    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = accept && (cfg_div == '0);
        load         = 1'b0;
        load_val     = cfg_div;
        if (apply) begin
            load         = 1'b1;
            load_val     = pend_q;
            pend_valid_d = 1'b0;
        end else if (good) begin
            if (state_q == IDLE) begin
                load = 1'b1;
            end else begin
                pend_d       = cfg_div;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    clk_div_core #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .clk_i      (clk_in),
        .rst_ni     (reset),
        .run_i      (run),
        .clr_i      (clr),
        .load_i     (load),
        .load_val_i (load_val),
        .bnd_o      (bnd),
        .clk_out_o  (clk_out),
        .tick_o     (tick),
        .div_o      (active_div)
    );

    assign cfg_err = cfg_err_q;
    assign busy    = run;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched; tick times are scoreboarded against a queue of expected cycles.
module tb_clk_div_sched;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;

    logic             clk_in = 1'b0;
    logic             reset, en, cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, clk_out, tick, busy;
    logic [CNT_W-1:0] active_div;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int exp_q[$];

    clk_div_sched #(.CNT_W(CNT_W), .DEF_DIV(DEF)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .active_div (active_div)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    // Every observed tick must match the next expected cycle number.
    always @(negedge clk_in) begin : mon
        int e;
        if (reset === 1'b1 && tick === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            tests++;
            assert (cyc === e) else begin
                fails++;
                $error("FAIL tick_time: got cycle %0d, want %0d", cyc, e);
            end
        end
    end

    initial begin
        int c, b, d, e;
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active_div", active_div, DEF);
        reset = 1'b1;
        @(negedge clk_in);
        chk("rel_cfg_ready", cfg_ready, 1);
        chk("rel_busy", busy, 0);

        // default divisor run, then mid-high reconfig to 2
        c = cyc;
        en = 1'b1;
        exp_q.push_back(c + 5); exp_q.push_back(c + 13); exp_q.push_back(c + 21);
        wait_until(c + 1);  chk("run_busy", busy, 1); chk("run_div", active_div, 4);
        wait_until(c + 4);  chk("pre_rise_low", clk_out, 0);
        wait_until(c + 5);  chk("first_rise", clk_out, 1);
        wait_until(c + 9);  chk("first_fall", clk_out, 0);
        wait_until(c + 22); cfg_valid = 1'b1; cfg_div = 8'd2;
        wait_until(c + 23); cfg_valid = 1'b0; chk("pend_not_ready", cfg_ready, 0);
        wait_until(c + 24); chk("pend_high_kept", clk_out, 1); chk("pend_div_old", active_div, 4);
        wait_until(c + 25); chk("pend_fall", clk_out, 0); chk("pend_applied", active_div, 2);
        chk("pend_ready_back", cfg_ready, 1);
        exp_q.push_back(c + 27); exp_q.push_back(c + 31);
        exp_q.push_back(c + 35); exp_q.push_back(c + 41);

        // zero divisor rejected while running
        wait_until(c + 32); cfg_valid = 1'b1; cfg_div = 8'd0;
        wait_until(c + 33); cfg_valid = 1'b0;
        chk("zero_run_err", cfg_err, 1); chk("zero_run_div", active_div, 2);
        chk("zero_run_clk", clk_out, 0);
        wait_until(c + 34); chk("zero_run_err_pulse", cfg_err, 0);

        // back to div 4, then stop while high
        wait_until(c + 35); cfg_valid = 1'b1; cfg_div = 8'd4;
        wait_until(c + 36); cfg_valid = 1'b0; chk("div4_not_ready", cfg_ready, 0);
        wait_until(c + 37); chk("div4_applied", active_div, 4); chk("div4_ready", cfg_ready, 1);
        wait_until(c + 42); en = 1'b0;
        wait_until(c + 44); chk("stop_hi_busy", busy, 1); chk("stop_hi_clk", clk_out, 1);
        wait_until(c + 45); chk("stop_hi_idle", busy, 0); chk("stop_hi_fall", clk_out, 0);

        // zero divisor rejected while idle
        wait_until(c + 46); cfg_valid = 1'b1; cfg_div = 8'd0;
        wait_until(c + 47); cfg_valid = 1'b0;
        chk("zero_idle_err", cfg_err, 1); chk("zero_idle_div", active_div, 4);
        chk("zero_idle_busy", busy, 0);
        wait_until(c + 48); chk("zero_idle_err_pulse", cfg_err, 0);

        // stop while low: idle next cycle, no extra edge
        b = c + 50;
        wait_until(b); en = 1'b1; exp_q.push_back(b + 5);
        wait_until(b + 10); en = 1'b0;
        wait_until(b + 11); chk("stop_lo_busy", busy, 1);
        wait_until(b + 12); chk("stop_lo_idle", busy, 0); chk("stop_lo_clk", clk_out, 0);
        wait_until(b + 14); chk("stop_lo_no_edge", clk_out, 0);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        wait_until(b + 15); cfg_valid = 1'b0;
        chk("idle_load_div1", active_div, 1); chk("idle_load_err", cfg_err, 0);

        // div 1 with en dropped and restored inside STOP
        d = b + 16;
        wait_until(d); en = 1'b1;
        for (int k = 2; k <= 12; k += 2) exp_q.push_back(d + k);
        wait_until(d + 2); chk("div1_rise", clk_out, 1);
        wait_until(d + 3); chk("div1_fall", clk_out, 0);
        wait_until(d + 5); en = 1'b0;
        wait_until(d + 6); chk("div1_stop_clk", clk_out, 1); chk("div1_stop_busy", busy, 1);
        en = 1'b1;
        wait_until(d + 7); chk("div1_resume_clk", clk_out, 0); chk("div1_resume_busy", busy, 1);
        wait_until(d + 8); chk("div1_resume_rise", clk_out, 1);
        wait_until(d + 12); chk("div1_phase_kept", clk_out, 1); en = 1'b0;
        wait_until(d + 13); chk("div1_end_fall", clk_out, 0); chk("div1_end_busy", busy, 1);
        wait_until(d + 14); chk("div1_end_idle", busy, 0); chk("div1_end_clk", clk_out, 0);

        // reset mid-high-phase with a divisor pending
        e = d + 16;
        wait_until(e); cfg_valid = 1'b1; cfg_div = 8'd3;
        wait_until(e + 1); cfg_valid = 1'b0; chk("div3_loaded", active_div, 3);
        wait_until(e + 2); en = 1'b1; exp_q.push_back(e + 6);
        wait_until(e + 6); chk("div3_rise", clk_out, 1); cfg_valid = 1'b1; cfg_div = 8'd5;
        wait_until(e + 7); cfg_valid = 1'b0;
        chk("rst_pend_not_ready", cfg_ready, 0); chk("rst_pend_high", clk_out, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_clk", clk_out, 0);
        chk("async_rst_div", active_div, DEF);
        chk("async_rst_busy", busy, 0);
        @(negedge clk_in); reset = 1'b1; en = 1'b0;
        @(negedge clk_in);
        chk("post_rst_ready", cfg_ready, 1);
        chk("post_rst_div", active_div, DEF);
        chk("post_rst_clk", clk_out, 0);
        chk("sb_empty", exp_q.size(), 0);

        repeat (2) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
